// File: rtl/moka_rv32i_sc_trace_tx.sv
// Commit-trace transmitter: captures retired-instruction records into a small FIFO
// and streams each record as 4 or 5 32-bit words over a valid/ready interface.
module moka_rv32i_sc_trace_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  commit_en,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic                  RegWrite,
  input  logic [4:0]            rd,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] RD2,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic [15:0]           drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, S_PC, S_INSTR, S_HDR, S_D0, S_D1} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wrPtr_q, rdPtr_q;
  logic [15:0]           seq_q;
  logic                  ovfPend_q;
  logic [15:0]           dropCnt_q;

  logic [DATA_WIDTH-1:0] pcMem    [DEPTH];
  logic [DATA_WIDTH-1:0] instrMem [DEPTH];
  logic [DATA_WIDTH-1:0] hdrMem   [DEPTH];
  logic [DATA_WIDTH-1:0] d0Mem    [DEPTH];
  logic [DATA_WIDTH-1:0] d1Mem    [DEPTH];
  logic                  mwMem    [DEPTH];

  logic                  push, drop, pop, moreAfterPop;
  logic [DATA_WIDTH-1:0] hdrWord, d0Word;

  // Acceptance looks only at the registered count, so a same-edge pop never frees a slot.
  assign push         = commit_en & (count_q < CW'(DEPTH));
  assign drop         = commit_en & ~push;
  assign moreAfterPop = (count_q > CW'(1));
  assign stall_req    = (count_q == CW'(DEPTH));
  assign drop_cnt     = dropCnt_q;

  assign hdrWord = {MemWrite, RegWrite, ovfPend_q, rd, 8'h00, seq_q};
  assign d0Word  = MemWrite ? ALUResult : (RegWrite ? WD3 : '0);

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr_q]    <= pc;
      instrMem[wrPtr_q] <= instruction;
      hdrMem[wrPtr_q]   <= hdrWord;
      d0Mem[wrPtr_q]    <= d0Word;
      d1Mem[wrPtr_q]    <= RD2;
      mwMem[wrPtr_q]    <= MemWrite;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      seq_q     <= '0;
      ovfPend_q <= 1'b0;
      dropCnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        wrPtr_q   <= wrPtr_q + PW'(1);
        ovfPend_q <= 1'b0;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      if (commit_en) begin
        seq_q <= seq_q + 16'd1;
      end
      if (drop) begin
        ovfPend_q <= 1'b1;
        if (dropCnt_q != 16'hFFFF) begin
          dropCnt_q <= dropCnt_q + 16'd1;
        end
      end
    end
  end

  // Outputs depend only on state and the head slot, so they hold while tx_ready is low.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = S_PC;
      end
      S_PC: begin
        tx_valid = 1'b1;
        tx_data  = pcMem[rdPtr_q];
        if (tx_ready) state_d = S_INSTR;
      end
      S_INSTR: begin
        tx_valid = 1'b1;
        tx_data  = instrMem[rdPtr_q];
        if (tx_ready) state_d = S_HDR;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdrMem[rdPtr_q];
        if (tx_ready) state_d = S_D0;
      end
      S_D0: begin
        tx_valid = 1'b1;
        tx_data  = d0Mem[rdPtr_q];
        tx_last  = ~mwMem[rdPtr_q];
        if (tx_ready) begin
          if (mwMem[rdPtr_q]) begin
            state_d = S_D1;
          end else begin
            pop     = 1'b1;
            state_d = moreAfterPop ? S_PC : IDLE;
          end
        end
      end
      S_D1: begin
        tx_valid = 1'b1;
        tx_data  = d1Mem[rdPtr_q];
        tx_last  = 1'b1;
        if (tx_ready) begin
          pop     = 1'b1;
          state_d = moreAfterPop ? S_PC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_moka_rv32i_sc_trace_tx.sv
// Self-checking bench for moka_rv32i_sc_trace_tx: expected stream words are queued
// as commits are driven and compared by a monitor as the DUT hands them off.
module tb_moka_rv32i_sc_trace_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit_en = 1'b0;
  logic [31:0] pc = '0, instruction = '0, WD3 = '0, ALUResult = '0, RD2 = '0;
  logic        RegWrite = 1'b0, MemWrite = 1'b0;
  logic [4:0]  rd = '0;
  logic        stall_req;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [32:0] expQ[$];
  logic [15:0] seqModel = '0;
  logic        ovfModel = 1'b0;
  bit          monEn = 1'b0;
  bit          holdPend = 1'b0;
  logic [31:0] holdData;
  logic        holdLast;

  moka_rv32i_sc_trace_tx #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .commit_en(commit_en), .pc(pc),
    .instruction(instruction), .RegWrite(RegWrite), .rd(rd), .WD3(WD3),
    .MemWrite(MemWrite), .ALUResult(ALUResult), .RD2(RD2),
    .stall_req(stall_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: inputs change just after posedge, so at negedge we see what the next edge will take.
  always @(negedge clk) begin
    logic [32:0] exp;
    if (monEn && rst_n) begin
      if (holdPend) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== holdData || tx_last !== holdLast) begin
          errors++;
          $display("[TB] FAIL hold_stable: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                   tx_valid, tx_data, tx_last, holdData, holdLast);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: got data=%h last=%b, none expected", tx_data, tx_last);
        end else begin
          exp = expQ.pop_front();
          if ({tx_last, tx_data} !== exp) begin
            errors++;
            $display("[TB] FAIL stream_word: got last=%b data=%h, need last=%b data=%h",
                     tx_last, tx_data, exp[32], exp[31:0]);
          end
        end
      end
      holdPend = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      holdData = tx_data;
      holdLast = tx_last;
    end else begin
      holdPend = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    monEn     = 1'b0;
    rst_n     = 1'b0;
    commit_en = 1'b0;
    tx_ready  = 1'b0;
    expQ.delete();
    seqModel  = '0;
    ovfModel  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    monEn = 1'b1;
  endtask

  task automatic commitOne(input logic [31:0] pcV, input logic [31:0] instrV,
                           input logic rwV, input logic mwV, input logic [4:0] rdV,
                           input logic [31:0] wd3V, input logic [31:0] aluV,
                           input logic [31:0] rd2V, input bit accept);
    logic [31:0] hdr, d0;
    if (accept) begin
      hdr = {mwV, rwV, ovfModel, rdV, 8'h00, seqModel};
      d0  = mwV ? aluV : (rwV ? wd3V : 32'h0);
      expQ.push_back({1'b0, pcV});
      expQ.push_back({1'b0, instrV});
      expQ.push_back({1'b0, hdr});
      expQ.push_back({~mwV, d0});
      if (mwV) expQ.push_back({1'b1, rd2V});
      ovfModel = 1'b0;
    end else begin
      ovfModel = 1'b1;
    end
    seqModel++;
    commit_en = 1'b1; pc = pcV; instruction = instrV; RegWrite = rwV; MemWrite = mwV;
    rd = rdV; WD3 = wd3V; ALUResult = aluV; RD2 = rd2V;
    @(posedge clk);
    #1;
    commit_en = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 300 && expQ.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d words still pending, need 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    doReset();
    checks += 5;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b need 0", tx_valid); end
    if (tx_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b need 0", tx_last); end
    if (tx_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h need 0", tx_data); end
    if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b need 0", stall_req); end
    if (drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_drop: got %h need 0", drop_cnt); end
  endtask

  task automatic test_single_alu();
    doReset();
    tx_ready = 1'b1;
    commitOne(32'h100, 32'h00500093, 1'b1, 1'b0, 5'd1, 32'h5, 32'h0, 32'h0, 1'b1);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL alu_latency_early: got valid=%b need 0", tx_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 32'h100) begin
      errors++; $display("[TB] FAIL alu_first_word: got valid=%b data=%h need valid=1 data=00000100", tx_valid, tx_data);
    end
    waitDrain("alu");
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL alu_idle_after: got valid=%b need 0", tx_valid);
    end
  endtask

  task automatic test_store();
    doReset();
    tx_ready = 1'b1;
    commitOne(32'h200, 32'h00000013, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
    commitOne(32'h204, 32'h00100113, 1'b1, 1'b0, 5'd2, 32'h1, 32'h0, 32'h0, 1'b1);
    commitOne(32'h208, 32'h00200193, 1'b1, 1'b0, 5'd3, 32'h2, 32'h0, 32'h0, 1'b1);
    commitOne(32'h20C, 32'h00112023, 1'b0, 1'b1, 5'd0, 32'h0, 32'h2000, 32'hDEADBEEF, 1'b1);
    waitDrain("store");
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    pat = 4'b1001;
    doReset();
    commitOne(32'h300, 32'h0041a023, 1'b0, 1'b1, 5'd0, 32'h0, 32'h3000, 32'hCAFEF00D, 1'b1);
    commitOne(32'h304, 32'h00a00293, 1'b1, 1'b0, 5'd5, 32'hA, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
      tx_ready = pat[i % 4];
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    waitDrain("backpressure");
  endtask

  task automatic test_back_to_back();
    int cyc;
    doReset();
    commitOne(32'h400, 32'h00100093, 1'b1, 1'b0, 5'd1, 32'h11, 32'h0, 32'h0, 1'b1);
    commitOne(32'h404, 32'h00200113, 1'b1, 1'b0, 5'd2, 32'h22, 32'h0, 32'h0, 1'b1);
    tx_ready = 1'b1;
    cyc = 0;
    while (expQ.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 8) begin
      errors++; $display("[TB] FAIL b2b_cycles: got %0d cycles need 8", cyc);
    end
    waitDrain("b2b");
  endtask

  task automatic test_overflow();
    doReset();
    for (int i = 0; i < 3; i++)
      commitOne(32'h500 + 32'(4 * i), 32'h00000013, 1'b1, 1'b0, 5'(i + 1), 32'(i), 32'h0, 32'h0, 1'b1);
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL ovf_stall_early: got %b need 0", stall_req); end
    commitOne(32'h50C, 32'h00000013, 1'b1, 1'b0, 5'd4, 32'h3, 32'h0, 32'h0, 1'b1);
    checks++;
    if (stall_req !== 1'b1) begin errors++; $display("[TB] FAIL ovf_stall_full: got %b need 1", stall_req); end
    commitOne(32'h510, 32'h00000013, 1'b1, 1'b0, 5'd5, 32'h4, 32'h0, 32'h0, 1'b0);
    commitOne(32'h514, 32'h00000013, 1'b1, 1'b0, 5'd6, 32'h5, 32'h0, 32'h0, 1'b0);
    checks++;
    if (drop_cnt !== 16'd2) begin errors++; $display("[TB] FAIL ovf_drop_cnt: got %0d need 2", drop_cnt); end
    tx_ready = 1'b1;
    waitDrain("ovf_records");
    commitOne(32'h518, 32'h00000013, 1'b1, 1'b0, 5'd7, 32'h6, 32'h0, 32'h0, 1'b1);
    waitDrain("ovf_next");
  endtask

  task automatic test_same_edge();
    doReset();
    for (int i = 0; i < 4; i++)
      commitOne(32'h600 + 32'(4 * i), 32'h00000013, 1'b1, 1'b0, 5'(i + 1), 32'(i + 16), 32'h0, 32'h0, 1'b1);
    checks++;
    if (stall_req !== 1'b1) begin errors++; $display("[TB] FAIL same_edge_full: got %b need 1", stall_req); end
    tx_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    commitOne(32'h610, 32'h00000013, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 32'h0, 1'b0);
    tx_ready = 1'b0;
    checks += 2;
    if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL same_edge_drop: got %0d need 1", drop_cnt); end
    if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL same_edge_count: got stall=%b need 0", stall_req); end
    tx_ready = 1'b1;
    waitDrain("same_edge_records");
    commitOne(32'h614, 32'h00000013, 1'b1, 1'b0, 5'd10, 32'hAA, 32'h0, 32'h0, 1'b1);
    waitDrain("same_edge_next");
  endtask

  task automatic test_reset_mid();
    doReset();
    commitOne(32'h700, 32'h00000013, 1'b1, 1'b0, 5'd1, 32'h7, 32'h0, 32'h0, 1'b1);
    commitOne(32'h704, 32'h00000013, 1'b1, 1'b0, 5'd2, 32'h8, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data[15:0] !== 16'h0000 || tx_data[30] !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_in_hdr: got valid=%b data=%h need valid=1 header seq 0", tx_valid, tx_data);
    end
    #2;
    monEn = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b need 0", tx_valid); end
    if (tx_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_data: got %h need 0", tx_data); end
    if (tx_last !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_last: got %b need 0", tx_last); end
    if (drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL mid_reset_drop: got %h need 0", drop_cnt); end
    doReset();
    tx_ready = 1'b1;
    commitOne(32'h800, 32'h00300213, 1'b1, 1'b0, 5'd4, 32'h3, 32'h0, 32'h0, 1'b1);
    waitDrain("mid_reset_new");
  endtask

  initial begin
    $display("[TB] starting moka_rv32i_sc_trace_tx bench");
    test_reset();
    test_single_alu();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_same_edge();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
